// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the core's
//   instruction-fetch port and its data port. One access is in flight at a
//   time: a one-cycle command is issued, read data is captured MEM_LAT edges
//   after the command edge, and the owning port receives a one-cycle ready
//   pulse. stall tells the pipeline that a pending request is not completing.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cs_i_n, i_addr             fetch request (active low) and address
//   i_data, i_ready            fetched word (held) and completion pulse
//   cs_d_n, rd, wr             data port select (active low), read, write
//   d_addr, d_wdata            data address and store data
//   d_data, d_ready            load data (held) and completion pulse
//   stall                      some pending request is not completing now
//   m_cs_n, m_we               memory select (active low), write enable
//   m_addr, m_wdata, m_rdata   memory address, write data, read data
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LAT     = 2,
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_i_n,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ready,
  input  logic              cs_d_n,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_data,
  output logic              d_ready,
  output logic              stall,
  output logic              m_cs_n,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  // Counter holds at most MEM_LAT-1; streak counts up to MAX_D_BURST.
  localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STREAK_W = $clog2(MAX_D_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [STREAK_W-1:0] streak_reg;
  logic                grant_i_reg;   // 1: access in flight belongs to fetch port
  logic                is_write_reg;

  logic i_req;
  logic d_req;
  logic fetch_starved;

  assign i_req = ~cs_i_n;
  // Data port selected with neither rd nor wr is not a request.
  assign d_req = ~cs_d_n & (rd | wr);
  // Fetch takes priority only once data has won MAX_D_BURST grants in a row.
  assign fetch_starved = i_req && (streak_reg == STREAK_W'(MAX_D_BURST));

  // Gated by rst_n so the pipeline is not frozen while reset is asserted.
  assign stall = rst_n & ((i_req & ~i_ready) | (d_req & ~d_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      streak_reg   <= '0;
      grant_i_reg  <= 1'b0;
      is_write_reg <= 1'b0;
      i_data       <= '0;
      d_data       <= '0;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      m_cs_n       <= 1'b1;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
    end else begin
      // Ready outputs are single-cycle pulses unless set below.
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (d_req && !fetch_starved) begin
            grant_i_reg  <= 1'b0;
            is_write_reg <= wr;          // rd&wr together is treated as a write
            m_cs_n       <= 1'b0;
            m_we         <= wr;
            m_addr       <= d_addr;
            m_wdata      <= d_wdata;
            cnt_reg      <= CNT_W'(MEM_LAT - 1);
            state_reg    <= CMD;
            // Count only grants that made a waiting fetch wait longer.
            // fetch_starved is false here, so the increment cannot overflow.
            streak_reg   <= i_req ? streak_reg + STREAK_W'(1) : '0;
          end else if (i_req) begin
            grant_i_reg  <= 1'b1;
            is_write_reg <= 1'b0;
            m_cs_n       <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= i_addr;
            cnt_reg      <= CNT_W'(MEM_LAT - 1);
            state_reg    <= CMD;
            streak_reg   <= '0;
          end else begin
            streak_reg   <= '0;
          end
        end
        CMD, WAIT: begin
          // Command lasts exactly one cycle; address/wdata simply hold.
          m_cs_n <= 1'b1;
          m_we   <= 1'b0;
          if (cnt_reg == '0) begin
            if (grant_i_reg) begin
              i_data <= m_rdata;
            end else if (!is_write_reg) begin
              d_data <= m_rdata;
            end
            i_ready   <= grant_i_reg;
            d_ready   <= ~grant_i_reg;
            state_reg <= RESP;
          end else begin
            cnt_reg   <= cnt_reg - CNT_W'(1);
            state_reg <= WAIT;
          end
        end
        RESP: begin
          // Requests are not looked at here; next sample is in IDLE.
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
